mem_access_sequencer: RTL and testbench
=======================================

// Module: mem_access_sequencer
// PURPOSE
// - Pipeline MEM-stage sequencer for LC-3b loads/stores: word, byte and indirect (LDI/STI).
// - Owns the mem_read/mem_write/mem_resp handshake and holds the pipeline via mem_stall.
// - Indirect accesses run as two memory transactions: pointer read, then data access.
// - Generalised over data width and byte lanes; returns zero-extended byte or full-word load data.
// PARAMETERS
// - DATA_W  16  data bus width; multiple of 8, >=16; LANES = DATA_W/8
// - ADDR_W  16  byte address width
// - LSB_W   $clog2(DATA_W/8)  derived; lane-select bits of the address
// PORTS
// - clk             in   1       clock; all state updates on rising edge
// - reset           in   1       synchronous, active-high
// - req_valid       in   1       MEM stage holds a memory instruction
// - req_op          in   2       00 NONE, 01 LOAD, 10 STORE, 11 reserved (treated as NONE)
// - req_indirect    in   1       LDI/STI: addr is the pointer location
// - req_byte        in   1       LDB/STB: single-lane access
// - req_addr        in   ADDR_W  effective address from ALU
// - req_wdata       in   DATA_W  store data (byte stores use bits [7:0])
// - mem_rdata       in   DATA_W  memory read data
// - mem_resp        in   1       memory completes current transaction
// - mem_address     out  ADDR_W  memory byte address
// - mem_read        out  1       read strobe, held until mem_resp
// - mem_write       out  1       write strobe, held until mem_resp
// - mem_wdata       out  DATA_W  write data
// - mem_byte_enable out  LANES   lane enables
// - ld_data         out  DATA_W  load result; valid in COMMIT
// - mem_stall       out  1       1 = upstream stages must hold
// - done            out  1       1-cycle pulse in COMMIT
// BEHAVIOUR
// - States: IDLE, PTR, DATA, COMMIT.
// - Reset: state=IDLE; ptr_reg, ld_data, latched request = 0.
//   All outputs 0 on the cycle after reset is sampled.
// - Reset mid-transaction abandons the transaction. mem_read/mem_write drop the next cycle.
// - IDLE: on req_valid & op in {LOAD,STORE}, latch op/indirect/byte/addr/wdata.
//   Go to PTR if indirect, else DATA. mem_stall=1 combinationally in this cycle.
// - PTR: mem_read=1; mem_address = addr with LSB_W bits cleared; byte_enable all 1s.
//   On mem_resp: ptr_reg <= mem_rdata[ADDR_W-1:0]; go DATA.
// - DATA: target = indirect ? ptr_reg : addr.
//   Word access: address = target with LSB bits cleared; byte_enable all 1s.
//   Byte access: address = target; byte_enable = one-hot lane target[LSB_W-1:0].
//   LOAD: mem_read=1; on mem_resp latch ld_data.
//     Word: ld_data = mem_rdata.
//     Byte: ld_data = zero-extended selected lane.
//   STORE: mem_write=1; mem_wdata = byte ? wdata[7:0] replicated to all lanes : wdata.
//   On mem_resp go COMMIT.
// - COMMIT: mem_stall=0, done=1, no strobes; next state IDLE.
//   A new request is accepted only from IDLE. Per instruction: 1 dead cycle (COMMIT->IDLE).
// - Latency, zero-wait memory: direct = 2 stall cycles + COMMIT; indirect = 3 + COMMIT.
//   Each memory wait cycle adds one stall cycle.
// - mem_stall = (state==IDLE & new request) | state in {PTR, DATA}.
// - Request inputs are ignored after latching. Dropping req_valid mid-access does not abort.
// - mem_resp in IDLE/COMMIT is ignored; strobes never both high.
// - A pointer read never uses byte mode, even for byte-indirect accesses.
// - op NONE/reserved: stays IDLE, mem_stall=0.
// CONFIGURATION
// - MEM_SEQ_STATS_EN defined: adds outputs stall_cycles[31:0] and access_count[31:0].
//   stall_cycles: +1 each cycle mem_stall=1.
//   access_count: +1 per mem_resp in PTR/DATA.
//   Both counters are cleared by reset and wrap at 2^32.
// - MEM_SEQ_STATS_EN undefined: those ports and counters do not exist.
//   All other behaviour is identical.
// TESTING
// - LOAD word, addr 0x3001, mem_resp after 2 waits, rdata 0xBEEF
//   -> mem_address 0x3000; ld_data 0xBEEF; mem_stall high 4 cycles; done 1 pulse.
// - LDB addr 0x3001, rdata 0xA55A
//   -> byte_enable 2'b10; ld_data 0x00A5. Same at 0x3000 -> 2'b01, ld_data 0x005A.
// - STB addr 0x4003, wdata 0x12C7 -> mem_write; wdata 0xC7C7; byte_enable 2'b10; done.
// - LDI addr 0x5000, pointer rdata 0x6002, data rdata 0x1234
//   -> reads at 0x5000 then 0x6002; ld_data 0x1234; 2 mem_resp consumed.
// - Reset asserted in DATA with mem_read high
//   -> next cycle mem_read=0, state IDLE, mem_stall=0; stray mem_resp ignored.
// - Back-to-back STR then LDR -> second request accepted only after COMMIT+IDLE.
//   With MEM_SEQ_STATS_EN: access_count=2.

Source files
------------

// File: rtl/mem_access_sequencer.sv
// Purpose : MEM-stage sequencer for LC-3b word/byte/indirect loads and stores.
// Latency : direct = 2 stall cycles + COMMIT, indirect = 3 + COMMIT, +1 stall per memory wait cycle.
// Backpressure: mem_stall holds upstream from request acceptance until the final mem_resp.
//
// Ports:
//   clk, reset                  clock and synchronous active-high reset
//   req_valid/op/indirect/byte  request from the MEM stage (op 01 LOAD, 10 STORE, else NONE)
//   req_addr, req_wdata         effective byte address and store data
//   mem_*                       memory handshake; strobes held until mem_resp
//   ld_data                     load result, valid while done is high
//   mem_stall, done             pipeline hold and one-cycle completion pulse
//   stall_cycles, access_count  statistics, present only when MEM_SEQ_STATS_EN is defined
//
// Optional feature macro: MEM_SEQ_STATS_EN (adds the statistics outputs and counters).
module mem_access_sequencer #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic [1:0]            req_op,
    input  logic                  req_indirect,
    input  logic                  req_byte,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_resp,
    output logic [ADDR_W-1:0]     mem_address,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_byte_enable,
    output logic [DATA_W-1:0]     ld_data,
    output logic                  mem_stall,
`ifdef MEM_SEQ_STATS_EN
    output logic [31:0]           stall_cycles,
    output logic [31:0]           access_count,
`endif
    output logic                  done
);

    localparam int LANES = DATA_W / 8;
    localparam int LSB_W = $clog2(DATA_W / 8);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PTR    = 2'd1,
        DATA   = 2'd2,
        COMMIT = 2'd3
    } stateT;

    stateT               state;
    stateT               nextState;

    // Request captured on acceptance; live request inputs are ignored afterwards.
    logic                latStore;
    logic                latIndirect;
    logic                latByte;
    logic [ADDR_W-1:0]   latAddr;
    logic [DATA_W-1:0]   latWdata;

    logic [ADDR_W-1:0]   ptrReg;
    logic [DATA_W-1:0]   ldDataReg;

    logic                newReq;
    logic [ADDR_W-1:0]   target;
    logic [LSB_W-1:0]    lane;
    logic [7:0]          laneByte;
    logic [DATA_W-1:0]   loadValue;

    assign newReq = req_valid && ((req_op == 2'b01) || (req_op == 2'b10));

    // Data phase address source: the fetched pointer for LDI/STI, else the ALU address.
    assign target   = latIndirect ? ptrReg : latAddr;
    assign lane     = target[LSB_W-1:0];
    assign laneByte = 8'(mem_rdata >> {lane, 3'b000});
    assign loadValue = latByte ? DATA_W'(laneByte) : mem_rdata;

    assign ld_data = ldDataReg;

    // Next-state and handshake outputs
    always_comb begin
        nextState       = state;
        mem_address     = '0;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_wdata       = '0;
        mem_byte_enable = '0;
        mem_stall       = 1'b0;
        done            = 1'b0;

        case (state)
            IDLE: begin
                if (newReq) begin
                    mem_stall = 1'b1;
                    nextState = req_indirect ? PTR : DATA;
                end
            end

            PTR: begin
                // Pointer fetch is always a full aligned word, even for byte-indirect ops.
                mem_stall       = 1'b1;
                mem_read        = 1'b1;
                mem_address     = {latAddr[ADDR_W-1:LSB_W], {LSB_W{1'b0}}};
                mem_byte_enable = '1;
                if (mem_resp) begin
                    nextState = DATA;
                end
            end

            DATA: begin
                mem_stall = 1'b1;
                if (latByte) begin
                    mem_address     = target;
                    mem_byte_enable = LANES'(1) << lane;
                end else begin
                    mem_address     = {target[ADDR_W-1:LSB_W], {LSB_W{1'b0}}};
                    mem_byte_enable = '1;
                end
                if (latStore) begin
                    mem_write = 1'b1;
                    mem_wdata = latByte ? {LANES{latWdata[7:0]}} : latWdata;
                end else begin
                    mem_read = 1'b1;
                end
                if (mem_resp) begin
                    nextState = COMMIT;
                end
            end

            COMMIT: begin
                done      = 1'b1;
                nextState = IDLE;
            end

            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Request latch, pointer and load-result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            latStore    <= 1'b0;
            latIndirect <= 1'b0;
            latByte     <= 1'b0;
            latAddr     <= '0;
            latWdata    <= '0;
            ptrReg      <= '0;
            ldDataReg   <= '0;
        end else begin
            if ((state == IDLE) && newReq) begin
                latStore    <= (req_op == 2'b10);
                latIndirect <= req_indirect;
                latByte     <= req_byte;
                latAddr     <= req_addr;
                latWdata    <= req_wdata;
            end
            if ((state == PTR) && mem_resp) begin
                ptrReg <= ADDR_W'(mem_rdata);
            end
            if ((state == DATA) && mem_resp && !latStore) begin
                ldDataReg <= loadValue;
            end
        end
    end

`ifdef MEM_SEQ_STATS_EN
    // Free-running statistics, wrapping at 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
            access_count <= '0;
        end else begin
            if (mem_stall) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (mem_resp && ((state == PTR) || (state == DATA))) begin
                access_count <= access_count + 32'd1;
            end
        end
    end
`else
    // Statistics build option disabled: no counters are instantiated.
`endif

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Purpose : self-checking bench for mem_access_sequencer against a transaction-level model.
// Latency : model predicts stall count as 1 + sum over accesses of (waits + 1).
// Backpressure: bench memory inserts random wait states and stray responses.
module tb_mem_access_sequencer;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic [1:0]  req_op;
    logic        req_indirect;
    logic        req_byte;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic [15:0] mem_rdata;
    logic        mem_resp;
    logic [15:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] mem_wdata;
    logic [1:0]  mem_byte_enable;
    logic [15:0] ld_data;
    logic        mem_stall;
    logic        done;
`ifdef MEM_SEQ_STATS_EN
    logic [31:0] stall_cycles;
    logic [31:0] access_count;
`endif

    int errCnt = 0;
    int chkCnt = 0;

    mem_access_sequencer #(.DATA_W(16), .ADDR_W(16)) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_op          (req_op),
        .req_indirect    (req_indirect),
        .req_byte        (req_byte),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .mem_rdata       (mem_rdata),
        .mem_resp        (mem_resp),
        .mem_address     (mem_address),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_wdata       (mem_wdata),
        .mem_byte_enable (mem_byte_enable),
        .ld_data         (ld_data),
        .mem_stall       (mem_stall),
`ifdef MEM_SEQ_STATS_EN
        .stall_cycles    (stall_cycles),
        .access_count    (access_count),
`endif
        .done            (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chkCnt++;
        if (obs !== exp) begin
            errCnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkVal({tag, "_read"}, 32'(mem_read), 32'd0);
        checkVal({tag, "_write"}, 32'(mem_write), 32'd0);
        checkVal({tag, "_stall"}, 32'(mem_stall), 32'd0);
        checkVal({tag, "_done"}, 32'(done), 32'd0);
        checkVal({tag, "_addr"}, 32'(mem_address), 32'd0);
    endtask

    // One instruction: model builds the expected list of memory accesses, then the
    // bench plays memory (random waits, stray responses) and compares cycle by cycle.
    task automatic runTxn(input logic isStore, input logic ind, input logic byt,
                          input logic [15:0] addr, input logic [15:0] wdata,
                          input int w0, input int w1,
                          input logic [15:0] rd0, input logic [15:0] rd1);
        logic [15:0] eAddr [2];
        logic [1:0]  eBe   [2];
        logic        eWr   [2];
        logic [15:0] eWd   [2];
        int          wt    [2];
        logic [15:0] rdv   [2];
        logic [15:0] tgt;
        logic [15:0] expLd;
        int          nAcc;
        int          expStall;
        int          idx;
        int          wc;
        int          stalls;
        logic        gotDone;
`ifdef MEM_SEQ_STATS_EN
        logic [31:0] scStart;
        logic [31:0] acStart;
`endif
        nAcc = 0;
        if (ind) begin
            eAddr[0] = addr & 16'hFFFE;
            eBe[0]   = 2'b11;
            eWr[0]   = 1'b0;
            eWd[0]   = 16'h0;
            wt[0]    = w0;
            rdv[0]   = rd0;
            nAcc     = 1;
        end
        tgt         = ind ? rd0 : addr;
        eAddr[nAcc] = byt ? tgt : (tgt & 16'hFFFE);
        eBe[nAcc]   = byt ? (tgt[0] ? 2'b10 : 2'b01) : 2'b11;
        eWr[nAcc]   = isStore;
        eWd[nAcc]   = byt ? {wdata[7:0], wdata[7:0]} : wdata;
        wt[nAcc]    = w1;
        rdv[nAcc]   = rd1;
        nAcc        = nAcc + 1;
        expLd       = byt ? ((rd1 >> (8 * int'(tgt[0]))) & 16'h00FF) : rd1;
        expStall    = 1;
        for (int i = 0; i < nAcc; i++) expStall += wt[i] + 1;

        idx = 0; wc = 0; stalls = 0; gotDone = 1'b0;
        for (int k = 0; k < 80 && !gotDone; k++) begin
            @(negedge clk);
            if (k == 0) begin
                req_valid = 1'b1; req_op = isStore ? 2'b10 : 2'b01;
                req_indirect = ind; req_byte = byt; req_addr = addr; req_wdata = wdata;
            end else begin
                // Post-acceptance request inputs must have no effect.
                req_valid = 1'($urandom); req_op = 2'($urandom);
                req_indirect = 1'($urandom); req_byte = 1'($urandom);
                req_addr = 16'($urandom); req_wdata = 16'($urandom);
            end
            mem_resp  = 1'b0;
            mem_rdata = 16'($urandom);
            #1;
`ifdef MEM_SEQ_STATS_EN
            if (k == 0) begin scStart = stall_cycles; acStart = access_count; end
`endif
            if (mem_stall) stalls++;
            if (mem_read || mem_write) begin
                checkVal("strobe_both", 32'(mem_read & mem_write), 32'd0);
                if (idx >= nAcc) begin
                    checkVal("extra_access", 32'(idx), 32'(nAcc));
                end else begin
                    checkVal("acc_addr", 32'(mem_address), 32'(eAddr[idx]));
                    checkVal("acc_be", 32'(mem_byte_enable), 32'(eBe[idx]));
                    checkVal("acc_write", 32'(mem_write), 32'(eWr[idx]));
                    if (eWr[idx]) checkVal("acc_wdata", 32'(mem_wdata), 32'(eWd[idx]));
                    if (wc == wt[idx]) begin
                        mem_resp = 1'b1; mem_rdata = rdv[idx]; idx++; wc = 0;
                    end else begin
                        wc++;
                    end
                end
            end else if (done) begin
                gotDone = 1'b1;
                checkVal("done_stall", 32'(mem_stall), 32'd0);
                checkVal("acc_count", 32'(idx), 32'(nAcc));
                checkVal("stall_cycles", 32'(stalls), 32'(expStall));
                if (!isStore) checkVal("ld_data", 32'(ld_data), 32'(expLd));
`ifdef MEM_SEQ_STATS_EN
                checkVal("stat_stall", stall_cycles - scStart, 32'(expStall));
                checkVal("stat_access", access_count - acStart, 32'(nAcc));
`endif
            end else begin
                mem_resp = 1'($urandom_range(0, 1));
            end
        end
        checkVal("txn_timeout", 32'(gotDone), 32'd1);
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_indirect = 1'b0;
        req_byte = 1'b0; req_addr = 16'h0; req_wdata = 16'h0;
        mem_rdata = 16'h0; mem_resp = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checkIdleOutputs("reset");
        checkVal("reset_ld", 32'(ld_data), 32'd0);
        checkVal("reset_be", 32'(mem_byte_enable), 32'd0);
`ifdef MEM_SEQ_STATS_EN
        checkVal("reset_stat_stall", stall_cycles, 32'd0);
        checkVal("reset_stat_access", access_count, 32'd0);
`endif
        @(negedge clk);
        reset = 1'b0;

        // Directed cases
        runTxn(1'b0, 1'b0, 1'b0, 16'h3001, 16'h0000, 0, 2, 16'h0000, 16'hBEEF);
        runTxn(1'b0, 1'b0, 1'b1, 16'h3001, 16'h0000, 0, 0, 16'h0000, 16'hA55A);
        runTxn(1'b0, 1'b0, 1'b1, 16'h3000, 16'h0000, 0, 1, 16'h0000, 16'hA55A);
        runTxn(1'b1, 1'b0, 1'b1, 16'h4003, 16'h12C7, 0, 0, 16'h0000, 16'h0000);
        runTxn(1'b0, 1'b1, 1'b0, 16'h5000, 16'h0000, 1, 0, 16'h6002, 16'h1234);
        runTxn(1'b1, 1'b1, 1'b1, 16'h5001, 16'h00E3, 0, 2, 16'h7005, 16'h0000);
        // Back-to-back STR then LDR
        runTxn(1'b1, 1'b0, 1'b0, 16'h2000, 16'hCAFE, 0, 0, 16'h0000, 16'h0000);
        runTxn(1'b0, 1'b0, 1'b0, 16'h2000, 16'h0000, 0, 0, 16'h0000, 16'h9876);

        // NONE / reserved ops never start an access
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            req_valid = 1'($urandom); req_op = (i % 2 == 0) ? 2'b00 : 2'b11;
            req_indirect = 1'($urandom); req_addr = 16'($urandom);
            mem_resp = 1'($urandom);
            #1;
            checkIdleOutputs("none_op");
        end

        // Reset while a direct load waits in DATA
        @(negedge clk);
        req_valid = 1'b1; req_op = 2'b01; req_indirect = 1'b0; req_byte = 1'b0;
        req_addr = 16'h1234; mem_resp = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        #1;
        checkVal("pre_reset_read", 32'(mem_read), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        #1;
        checkIdleOutputs("mid_reset");
        checkVal("mid_reset_ld", 32'(ld_data), 32'd0);
        reset = 1'b0;
        mem_resp = 1'b1;
        repeat (2) begin
            @(negedge clk);
            #1;
            checkIdleOutputs("stray_resp");
        end
        mem_resp = 1'b0;

        // Randomized instructions
        for (int n = 0; n < 40; n++) begin
            runTxn(1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   16'($urandom), 16'($urandom));
        end

        @(negedge clk);
        req_valid = 1'b0; mem_resp = 1'b0;
        @(negedge clk);
        #1;
        checkIdleOutputs("final_idle");

        $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
        $finish;
    end

endmodule
